// File: rtl/sensor_channel_fifo_array_if.sv
// Write/read stream bundle for sensor_channel_fifo_array: tagged write port and tagged valid/ready output.
interface sensor_channel_fifo_array_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_WIDTH   = 2
);
    logic                  wr_valid;
    logic [CH_WIDTH-1:0]   wr_channel;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [CH_WIDTH-1:0]   rd_channel;

    modport master (
        output wr_valid, wr_channel, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_channel
    );

    modport slave (
        input  wr_valid, wr_channel, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_channel
    );
endinterface

// File: rtl/sensor_channel_fifo_array.sv
// NUM_CHANNELS independent FIFOs behind one tagged write port, drained round-robin into a registered output.
// Optional build macro SENSOR_FIFO_STICKY_ERR_EN: sticky overflow flags cleared by err_clear (default: one-cycle pulses).
module sensor_channel_fifo_array #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CH_WIDTH     = $clog2(NUM_CHANNELS),
    parameter int ADDR_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    sensor_channel_fifo_array_if.slave             bus,
    input  logic [NUM_CHANNELS-1:0]                ch_enable,
    input  logic [NUM_CHANNELS-1:0]                ch_flush,
    input  logic [ADDR_WIDTH:0]                    afull_thresh,
    input  logic                                   err_clear,
    output logic [NUM_CHANNELS-1:0]                ch_full,
    output logic [NUM_CHANNELS-1:0]                ch_empty,
    output logic [NUM_CHANNELS-1:0]                ch_almost_full,
    output logic [NUM_CHANNELS-1:0]                ch_overflow,
    output logic [NUM_CHANNELS*(ADDR_WIDTH+1)-1:0] ch_fill_level,
    output logic [15:0]                            write_count,
    output logic [15:0]                            read_count,
    output logic [15:0]                            drop_count
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [NUM_CHANNELS][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CHANNELS];
    logic [PW-1:0]         rd_ptr [NUM_CHANNELS];
    logic [PW-1:0]         fill [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] wr_sel;
    logic [NUM_CHANNELS-1:0] wr_en;
    logic [NUM_CHANNELS-1:0] drop;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] pop;

    logic [CH_WIDTH-1:0]   last_grant;
    logic [CH_WIDTH-1:0]   grant;
    logic                  grant_found;
    logic                  load;
    logic [DATA_WIDTH-1:0] pop_data;

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [CH_WIDTH-1:0]   rd_channel_q;

    always_comb begin
        ch_fill_level  = '0;
        ch_full        = '0;
        ch_empty       = '0;
        ch_almost_full = '0;
        wr_sel         = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            fill[i]           = wr_ptr[i] - rd_ptr[i];
            ch_empty[i]       = (wr_ptr[i] == rd_ptr[i]);
            ch_full[i]        = (wr_ptr[i][ADDR_WIDTH-1:0] == rd_ptr[i][ADDR_WIDTH-1:0]) &&
                                (wr_ptr[i][ADDR_WIDTH] != rd_ptr[i][ADDR_WIDTH]);
            ch_almost_full[i] = (fill[i] >= afull_thresh);
            ch_fill_level[i*PW +: PW] = fill[i];
            wr_sel[i]         = (bus.wr_channel == CH_WIDTH'(i));
        end
    end

    // A flushed channel swallows its same-cycle write silently and is excluded from arbitration.
    assign bus.wr_ready = !(|(wr_sel & ch_full));
    assign wr_en        = {NUM_CHANNELS{bus.wr_valid}} & wr_sel & ~ch_full & ~ch_flush;
    assign drop         = {NUM_CHANNELS{bus.wr_valid}} & wr_sel &  ch_full & ~ch_flush;
    assign eligible     = ch_enable & ~ch_empty & ~ch_flush;
    assign load         = (!rd_valid_q || bus.rd_ready) && grant_found;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        pop_data    = '0;
        pop         = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (!grant_found && eligible[i] &&
                    ((int'(last_grant) + k == i) || (int'(last_grant) + k == i + NUM_CHANNELS))) begin
                    grant_found = 1'b1;
                    grant       = CH_WIDTH'(i);
                end
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_found && grant == CH_WIDTH'(i)) begin
                pop_data = mem[i][rd_ptr[i][ADDR_WIDTH-1:0]];
                pop[i]   = load;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr[i][ADDR_WIDTH-1:0]] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            last_grant   <= CH_WIDTH'(NUM_CHANNELS - 1);
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_channel_q <= '0;
            write_count  <= '0;
            read_count   <= '0;
            drop_count   <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (ch_flush[i]) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end else begin
                    if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
            if (load) begin
                rd_valid_q   <= 1'b1;
                rd_data_q    <= pop_data;
                rd_channel_q <= grant;
                last_grant   <= grant;
            end else if (bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
            if (|wr_en)                       write_count <= write_count + 16'd1;
            if (rd_valid_q && bus.rd_ready)   read_count  <= read_count + 16'd1;
            if (|drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

`ifdef SENSOR_FIFO_STICKY_ERR_EN
    // A new overflow wins over a coincident clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ch_overflow <= '0;
        end else begin
            ch_overflow <= drop | (err_clear ? '0 : ch_overflow);
        end
    end
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ch_overflow <= '0;
        end else begin
            ch_overflow <= drop;
        end
    end
`endif

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_channel = rd_channel_q;

endmodule

// File: tb/tb_sensor_channel_fifo_array.sv
// Directed plus randomized bench for sensor_channel_fifo_array, checked every cycle against a queue-based model.
module tb_sensor_channel_fifo_array;
    localparam int DW    = 32;
    localparam int NC    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int AW    = 4;
    localparam int FW    = AW + 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic [NC-1:0] ch_enable;
    logic [NC-1:0] ch_flush;
    logic [FW-1:0] afull_thresh;
    logic          err_clear;
    logic [NC-1:0] ch_full, ch_empty, ch_almost_full, ch_overflow;
    logic [NC*FW-1:0] ch_fill_level;
    logic [15:0]   write_count, read_count, drop_count;

    sensor_channel_fifo_array_if #(.DATA_WIDTH(DW), .CH_WIDTH(CW)) bus ();

    sensor_channel_fifo_array #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave),
        .ch_enable(ch_enable),
        .ch_flush(ch_flush),
        .afull_thresh(afull_thresh),
        .err_clear(err_clear),
        .ch_full(ch_full),
        .ch_empty(ch_empty),
        .ch_almost_full(ch_almost_full),
        .ch_overflow(ch_overflow),
        .ch_fill_level(ch_fill_level),
        .write_count(write_count),
        .read_count(read_count),
        .drop_count(drop_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per channel plus the output register contents.
    logic [DW-1:0] mq [NC][$];
    logic          m_rv;
    logic [DW-1:0] m_rdata;
    logic [CW-1:0] m_rch;
    int            m_last;
    logic [15:0]   m_wcnt, m_rcnt, m_dcnt;
    logic [NC-1:0] m_ovf;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        for (int c = 0; c < NC; c++) begin
            checkOutput($sformatf("fill%0d", c), 64'(ch_fill_level[c*FW +: FW]), 64'(mq[c].size()));
            checkOutput($sformatf("empty%0d", c), 64'(ch_empty[c]), 64'(mq[c].size() == 0));
            checkOutput($sformatf("full%0d", c), 64'(ch_full[c]), 64'(mq[c].size() == DEPTH));
            checkOutput($sformatf("afull%0d", c), 64'(ch_almost_full[c]), 64'(mq[c].size() >= int'(afull_thresh)));
            checkOutput($sformatf("ovf%0d", c), 64'(ch_overflow[c]), 64'(m_ovf[c]));
        end
        checkOutput("wr_ready", 64'(bus.wr_ready), 64'(mq[bus.wr_channel].size() != DEPTH));
        checkOutput("rd_valid", 64'(bus.rd_valid), 64'(m_rv));
        checkOutput("rd_data", 64'(bus.rd_data), 64'(m_rdata));
        checkOutput("rd_channel", 64'(bus.rd_channel), 64'(m_rch));
        checkOutput("write_count", 64'(write_count), 64'(m_wcnt));
        checkOutput("read_count", 64'(read_count), 64'(m_rcnt));
        checkOutput("drop_count", 64'(drop_count), 64'(m_dcnt));
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic modelStep();
        logic [NC-1:0] ovf_ev;
        bit            push;
        int            wch;
        int            grant;
        if (!reset) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_rv = 1'b0; m_rdata = '0; m_rch = '0; m_last = NC - 1;
            m_wcnt = '0; m_rcnt = '0; m_dcnt = '0; m_ovf = '0;
            return;
        end
        ovf_ev = '0;
        push   = 1'b0;
        wch    = int'(bus.wr_channel);
        if (bus.wr_valid && !ch_flush[wch]) begin
            if (mq[wch].size() == DEPTH) begin
                ovf_ev[wch] = 1'b1;
                if (m_dcnt != 16'hFFFF) m_dcnt++;
            end else begin
                push = 1'b1;
                m_wcnt++;
            end
        end
        if (m_rv && bus.rd_ready) m_rcnt++;
        if (!m_rv || bus.rd_ready) begin
            grant = -1;
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_last + k) % NC;
                if (grant < 0 && ch_enable[c] && !ch_flush[c] && mq[c].size() > 0) grant = c;
            end
            if (grant >= 0) begin
                m_rdata = mq[grant].pop_front();
                m_rch   = CW'(grant);
                m_rv    = 1'b1;
                m_last  = grant;
            end else begin
                m_rv = 1'b0;
            end
        end
        if (push) mq[wch].push_back(bus.wr_data);
        for (int c = 0; c < NC; c++) if (ch_flush[c]) mq[c].delete();
`ifdef SENSOR_FIFO_STICKY_ERR_EN
        m_ovf = ovf_ev | (err_clear ? '0 : m_ovf);
`else
        m_ovf = ovf_ev;
`endif
    endtask

    task automatic applyStimulus(input bit do_check);
        @(negedge clock);
        if (do_check) compareAll();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic doWrite(input int ch, input logic [DW-1:0] d);
        bus.wr_valid   = 1'b1;
        bus.wr_channel = CW'(ch);
        bus.wr_data    = d;
        applyStimulus(1);
        bus.wr_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1);
    endtask

    initial begin
        reset          = 1'b0;
        ch_enable      = '1;
        ch_flush       = '0;
        afull_thresh   = FW'(12);
        err_clear      = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_channel = '0;
        bus.wr_data    = '0;
        bus.rd_ready   = 1'b0;
        applyStimulus(0);
        applyStimulus(0);
        reset = 1'b1;
        idle(2);

        // Basic ordering on one channel.
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) doWrite(1, DW'(32'hA0 + i));
        idle(5);

        // Fill a disabled channel to the brim, overflow it, then watch the flag.
        ch_enable = 4'b1110;
        for (int i = 0; i < DEPTH; i++) doWrite(0, DW'(32'h100 + i));
        doWrite(0, DW'(32'hDEAD));
        idle(4);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        idle(2);
        ch_enable = '1;
        idle(20);

        // Round-robin fairness across all channels, then a partial refill.
        bus.rd_ready = 1'b0;
        for (int c = 0; c < NC; c++) doWrite(c, DW'(32'h200 + c));
        bus.rd_ready = 1'b1;
        idle(6);
        bus.rd_ready = 1'b0;
        doWrite(0, DW'(32'h300));
        doWrite(2, DW'(32'h302));
        bus.rd_ready = 1'b1;
        idle(4);

        // Back-pressure hold, then a disabled channel kept out of arbitration.
        bus.rd_ready = 1'b0;
        doWrite(1, DW'(32'h401));
        doWrite(1, DW'(32'h402));
        idle(5);
        ch_enable = 4'b1011;
        for (int i = 0; i < 3; i++) doWrite(2, DW'(32'h500 + i));
        bus.rd_ready = 1'b1;
        idle(6);
        ch_enable = '1;
        idle(6);

        // Flush racing a write, then almost-full thresholds.
        ch_enable = 4'b0111;
        for (int i = 0; i < 8; i++) doWrite(3, DW'(32'h600 + i));
        ch_flush = 4'b1000;
        doWrite(3, DW'(32'h6FF));
        ch_flush = '0;
        idle(1);
        afull_thresh = FW'(4);
        for (int i = 0; i < 4; i++) doWrite(3, DW'(32'h700 + i));
        idle(2);
        afull_thresh = '0;
        idle(2);
        afull_thresh = FW'(DEPTH);
        ch_enable = '1;
        idle(8);

        // Reset in the middle of traffic.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) doWrite(i % NC, DW'(32'h800 + i));
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(2);

        // Randomized traffic with alternating back-pressure phases.
        for (int n = 0; n < 4000; n++) begin
            int ready_pct;
            ready_pct      = ((n / 200) % 2 == 1) ? 20 : 90;
            reset          = ($urandom_range(0, 399) != 0);
            bus.wr_valid   = ($urandom_range(0, 3) != 0);
            bus.wr_channel = CW'($urandom_range(0, NC - 1));
            bus.wr_data    = DW'($urandom);
            bus.rd_ready   = ($urandom_range(0, 99) < ready_pct);
            for (int c = 0; c < NC; c++) begin
                ch_enable[c] = ($urandom_range(0, 7) != 0);
                ch_flush[c]  = ($urandom_range(0, 99) == 0);
            end
            err_clear    = ($urandom_range(0, 15) == 0);
            afull_thresh = FW'($urandom_range(0, DEPTH));
            applyStimulus(1);
        end
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        ch_flush     = '0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sensor_channel_fifo_array.md
# sensor_channel_fifo_array

Multi-channel successor to the single-stream sensor data FIFO: NUM_CHANNELS independent FIFOs share one write port with a channel tag. A round-robin arbiter drains them into a single registered valid/ready output stream tagged with the source channel. It sits between the multi-channel ADC front-end and the processing pipeline. It adds per-channel flush, per-channel enable, a runtime almost-full threshold, and drop counting.

## Interface
- DATA_WIDTH, 32, sample width
- NUM_CHANNELS, 4, channel count (≥2)
- FIFO_DEPTH, 16, entries per channel (power of 2, ≥2)
- CH_WIDTH, $clog2(NUM_CHANNELS), channel tag width
- ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer index width
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- wr_valid  in  1  write request
- wr_channel  in  CH_WIDTH  target channel
- wr_data  in  DATA_WIDTH  sample
- wr_ready  out  1  combinational: target channel not full
- rd_valid  out  1  output register holds a word
- rd_ready  in  1  consumer accepts
- rd_data  out  DATA_WIDTH  output word
- rd_channel  out  CH_WIDTH  source channel of rd_data
- ch_enable  in  NUM_CHANNELS  channel eligible for arbitration
- ch_flush  in  NUM_CHANNELS  per-channel flush, level-sampled
- afull_thresh  in  ADDR_WIDTH+1  almost-full threshold, shared by all channels
- err_clear  in  1  clears overflow flags
- ch_full, ch_empty, ch_almost_full, ch_overflow  out  NUM_CHANNELS each  per-channel status
- ch_fill_level  out  NUM_CHANNELS*(ADDR_WIDTH+1)  channel i in bits [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
- write_count, read_count  out  16 each  accepted writes / output handshakes, wrap modulo 2^16
- drop_count  out  16  rejected writes, saturates at 0xFFFF

## Operation
- Per channel: storage FIFO_DEPTH×DATA_WIDTH, pointers with wrap bit (ADDR_WIDTH+1 bits); full = indices equal and wrap bits differ; empty = pointers equal; fill = wr_ptr − rd_ptr (mod 2^(ADDR_WIDTH+1)).
- Write: wr_valid && !ch_full[wr_channel] stores the word, advances the pointer, and increments write_count. wr_valid && full drops the word, raises overflow, and increments drop_count. Writes to disabled channels are accepted.
- Output load condition: (!rd_valid || rd_ready) and at least one channel with ch_enable=1 and !ch_empty. The arbiter picks the first eligible channel searching from (last_grant+1) mod NUM_CHANNELS upward, pops one word into rd_data/rd_channel, sets rd_valid, and updates last_grant.
- With no eligible channel and rd_ready=1: rd_valid clears.
- rd_valid && !rd_ready: rd_data/rd_channel held stable, no pop.
- read_count increments on each rd_valid && rd_ready.
- ch_almost_full[i] = fill_i ≥ afull_thresh. With afull_thresh=0 it is always 1.
- ch_flush[i]: both pointers of channel i reset to 0 at the next edge. The flush beats a same-cycle write (write dropped, no overflow, no drop_count) and a same-cycle pop (no pop from i). A word already in the output register is unaffected.
- Same-channel write and pop in one cycle: both occur, fill unchanged; a write to a full channel succeeds only if that channel is not full in the current cycle (no write-through-on-pop).
- Reset (reset=0 at an edge, any time): pointers, counters, last_grant=NUM_CHANNELS−1, rd_valid=0, rd_data=0, rd_channel=0, overflow=0. After reset: ch_empty all 1, ch_full/ch_almost_full 0 (given afull_thresh>0), fill 0, wr_ready=1.

## Timing
- Write sampled at edge k: ch_fill_level/ch_empty updated after k; earliest rd_valid after edge k+1 (2-edge write-to-output latency).
- Status outputs are combinational from registered pointers. wr_ready depends combinationally on wr_channel.
- Sustained throughput: one write and one output word per clock when rd_ready=1.
- Overflow flag reflects a rejected write from edge k onward (sticky or pulse, see Configuration).

## Configuration
- SENSOR_FIFO_STICKY_ERR_EN defined: ch_overflow[i] stays set until err_clear=1 at an edge. When a new overflow and err_clear coincide, the flag stays set.
- Not defined: ch_overflow[i] is a one-cycle pulse after each rejected write, and err_clear is ignored.
- drop_count behaves identically in both builds.

## Test plan
- Reset then write 0xA0..0xA2 to ch1 → ch_fill_level[1]=3; outputs 0xA0,0xA1,0xA2 with rd_channel=1 in order; write_count=3, read_count=3.
- Fill ch0 with 16 words, write 0xDEAD to ch0 → wr_ready=0, word dropped, ch_overflow[0]=1, drop_count=1, fill stays 16.
- One word each in ch0–ch3, rd_ready=1 → rd_channel sequence 0,1,2,3; then refill ch0 and ch2 → 0,2.
- rd_ready=0 for 5 cycles with rd_valid=1 → rd_data stable, no fill change; ch_enable[2]=0 → ch2 words never output until re-enabled.
- Flush ch3 holding 8 words while writing it → ch_fill_level[3]=0 next cycle, write dropped, drop_count unchanged; afull_thresh=4 with 4 words → ch_almost_full=1.
- Overflow then wait 3 cycles → flag held (sticky build) or low after 1 cycle (pulse build); err_clear clears it in the sticky build; reset mid-stream clears rd_valid and all counters.
